// File: rtl/rpn_lan_rx.sv
// LAN receive path: accepts PUB messages, filters them against the per-sender
// sequence number held in BRAM, delivers new payloads to the node and acknowledges.
module rpn_lan_rx #(
  parameter int unsigned NODE_ID_WIDTH             = 8,
  parameter int unsigned LAN_SEQUENCE_NUMBER_WIDTH = 16,
  parameter int unsigned AXIS_DATA_WIDTH           = 512,
  parameter int unsigned PUB_DATA_WIDTH            = 256,
  parameter int unsigned BRAM_ADDR_WIDTH           = 32
) (
  input  logic                                 i_clk,
  input  logic                                 i_ap_rst_n,
  input  logic                                 i_sequence_numbers_initialized,
  input  logic [NODE_ID_WIDTH-1:0]             i_node_id,

  input  logic                                 from_nb_LAN_tvalid,
  output logic                                 from_nb_LAN_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]           from_nb_LAN_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]         from_nb_LAN_tkeep,
  input  logic [NODE_ID_WIDTH-1:0]             from_nb_LAN_tid,
  input  logic [NODE_ID_WIDTH-1:0]             from_nb_LAN_tdest,
  input  logic                                 from_nb_LAN_tuser,
  input  logic                                 from_nb_LAN_tlast,

  output logic                                 to_node_tvalid,
  input  logic                                 to_node_tready,
  output logic [AXIS_DATA_WIDTH-1:0]           to_node_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]         to_node_tkeep,
  output logic [NODE_ID_WIDTH-1:0]             to_node_tid,
  output logic [NODE_ID_WIDTH-1:0]             to_node_tdest,
  output logic                                 to_node_tlast,

  output logic                                 to_nb_ack_tvalid,
  input  logic                                 to_nb_ack_tready,
  output logic [AXIS_DATA_WIDTH-1:0]           to_nb_ack_tdata,
  output logic [NODE_ID_WIDTH-1:0]             to_nb_ack_tdest,
  output logic                                 to_nb_ack_tuser,
  output logic                                 to_nb_ack_tlast,

  output logic                                 seq_BRAM_CLK,
  output logic                                 seq_BRAM_RST,
  output logic                                 seq_BRAM_EN,
  output logic [BRAM_ADDR_WIDTH-1:0]           seq_BRAM_ADDR,
  input  logic [LAN_SEQUENCE_NUMBER_WIDTH-1:0] seq_BRAM_DOUT,
  output logic [3:0]                           seq_BRAM_WEN,
  output logic [LAN_SEQUENCE_NUMBER_WIDTH-1:0] seq_BRAM_DIN
);

  localparam int unsigned KEEP_WIDTH = AXIS_DATA_WIDTH / 8;
  localparam logic [3:0]  TYPE_PUB   = 4'd1;
  localparam logic [3:0]  TYPE_ACK   = 4'd2;

  typedef enum logic [2:0] {INIT, IDLE, READ_SEQ, CHECK, DELIVER, SEND_ACK} state_t;

  state_t                                state;
  logic [NODE_ID_WIDTH-1:0]              sender;
  logic [LAN_SEQUENCE_NUMBER_WIDTH-1:0]  seq;
  logic [PUB_DATA_WIDTH-1:0]             payload;
  logic [KEEP_WIDTH-1:0]                 keep_q;
  logic [NODE_ID_WIDTH-1:0]              tid_q;
  logic [NODE_ID_WIDTH-1:0]              tdest_q;

  logic [3:0]                            in_type;
  logic [NODE_ID_WIDTH-1:0]              in_sender;
  logic [NODE_ID_WIDTH-1:0]              bram_node;
  logic [LAN_SEQUENCE_NUMBER_WIDTH-1:0]  next_expected;
  logic                                  accept_pub;
  logic                                  write_seq;
  logic                                  unused_inputs;

  assign in_type       = from_nb_LAN_tdata[3:0];
  assign in_sender     = from_nb_LAN_tdata[4 +: NODE_ID_WIDTH];
  assign next_expected = seq_BRAM_DOUT + 1'b1;
  assign unused_inputs = ^{from_nb_LAN_tdata, from_nb_LAN_tuser, from_nb_LAN_tlast};

  assign from_nb_LAN_tready = (state == IDLE);
  assign accept_pub = from_nb_LAN_tready && from_nb_LAN_tvalid && (in_type == TYPE_PUB);
  assign write_seq  = (state == DELIVER) && to_node_tready;

  // The read is issued from the incoming beat so DOUT is ready by CHECK.
  assign bram_node     = write_seq ? sender : in_sender;
  assign seq_BRAM_CLK  = i_clk;
  assign seq_BRAM_RST  = ~i_ap_rst_n;
  assign seq_BRAM_EN   = accept_pub || write_seq;
  assign seq_BRAM_WEN  = write_seq ? 4'hF : 4'h0;
  assign seq_BRAM_ADDR = BRAM_ADDR_WIDTH'(bram_node) << 2;
  assign seq_BRAM_DIN  = seq;

  assign to_node_tvalid = (state == DELIVER);
  assign to_node_tdata  = AXIS_DATA_WIDTH'(payload);
  assign to_node_tkeep  = keep_q;
  assign to_node_tid    = tid_q;
  assign to_node_tdest  = tdest_q;
  assign to_node_tlast  = (state == DELIVER);

  assign to_nb_ack_tvalid = (state == SEND_ACK);
  assign to_nb_ack_tdest  = sender;
  assign to_nb_ack_tuser  = (state == SEND_ACK);
  assign to_nb_ack_tlast  = (state == SEND_ACK);

  always_comb begin
    to_nb_ack_tdata                                  = '0;
    to_nb_ack_tdata[3:0]                             = TYPE_ACK;
    to_nb_ack_tdata[4 +: NODE_ID_WIDTH]              = i_node_id;
    to_nb_ack_tdata[32 +: LAN_SEQUENCE_NUMBER_WIDTH] = seq;
  end

  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      state   <= INIT;
      sender  <= '0;
      seq     <= '0;
      payload <= '0;
      keep_q  <= '0;
      tid_q   <= '0;
      tdest_q <= '0;
    end else begin
      case (state)
        INIT:     if (i_sequence_numbers_initialized) state <= IDLE;
        IDLE: begin
          if (accept_pub) begin
            sender  <= in_sender;
            seq     <= from_nb_LAN_tdata[32 +: LAN_SEQUENCE_NUMBER_WIDTH];
            payload <= from_nb_LAN_tdata[64 +: PUB_DATA_WIDTH];
            keep_q  <= from_nb_LAN_tkeep;
            tid_q   <= from_nb_LAN_tid;
            tdest_q <= from_nb_LAN_tdest;
            state   <= READ_SEQ;
          end
        end
        READ_SEQ: state <= CHECK;
        CHECK: begin
          if (seq == next_expected)      state <= DELIVER;
          else if (seq == seq_BRAM_DOUT) state <= SEND_ACK;
          else                           state <= IDLE;
        end
        DELIVER:  if (to_node_tready)   state <= SEND_ACK;
        SEND_ACK: if (to_nb_ack_tready) state <= IDLE;
        default:  state <= INIT;
      endcase
    end
  end

endmodule

// File: doc/rpn_lan_rx.md
RPN_LAN_RX -- requirements
Module: rpn_LAN_RX

Interface
REQ-001 SHALL have parameters: NODE_ID_WIDTH, default 8, node ID width; LAN_SEQUENCE_NUMBER_WIDTH, default 16, sequence number width; AXIS_DATA_WIDTH, default 512, stream data width; PUB_DATA_WIDTH, default 256, PUB payload width; BRAM_ADDR_WIDTH, default 32, BRAM byte address width.
REQ-002 SHALL have ports, clock and reset first: i_clk in 1, clock; i_ap_rst_n in 1, reset, asynchronous, active-low.
REQ-003 SHALL have ports: i_sequence_numbers_initialized in 1, enables operation; i_node_id in NODE_ID_WIDTH, own node ID.
REQ-004 SHALL have input stream from_nb_LAN_*: tvalid in 1, tready out 1, tdata in AXIS_DATA_WIDTH, tkeep in AXIS_DATA_WIDTH/8, tid in NODE_ID_WIDTH, tdest in NODE_ID_WIDTH, tuser in 1, tlast in 1.
REQ-005 SHALL have output stream to_node_*: tvalid out 1, tready in 1, tdata out AXIS_DATA_WIDTH, tkeep out AXIS_DATA_WIDTH/8, tid out NODE_ID_WIDTH, tdest out NODE_ID_WIDTH, tlast out 1.
REQ-006 SHALL have output stream to_nb_ack_*: tvalid out 1, tready in 1, tdata out AXIS_DATA_WIDTH, tdest out NODE_ID_WIDTH, tuser out 1, tlast out 1.
REQ-007 SHALL have BRAM port seq_BRAM_*: CLK out 1 (=i_clk), RST out 1 (=~i_ap_rst_n), EN out 1, ADDR out BRAM_ADDR_WIDTH, DOUT in LAN_SEQUENCE_NUMBER_WIDTH, WEN out 4, DIN out LAN_SEQUENCE_NUMBER_WIDTH; stores the last accepted sequence number per sender.

Function
REQ-008 Message layout SHALL be: tdata[3:0] type (PUB=1, ACK=2); [4+:NODE_ID_WIDTH] sender node ID; [32+:LAN_SEQUENCE_NUMBER_WIDTH] sequence number; [64+:PUB_DATA_WIDTH] payload.
REQ-009 States SHALL be INIT, IDLE, READ_SEQ, CHECK, DELIVER, SEND_ACK.
REQ-010 INIT->IDLE when i_sequence_numbers_initialized=1; no input accepted in INIT.
REQ-011 from_nb_LAN_tready SHALL be 1 only in IDLE; a beat is accepted on tvalid&&tready.
REQ-012 Accepted beat with type!=PUB SHALL be consumed and dropped, staying in IDLE.
REQ-013 Accepted PUB SHALL latch sender, sequence number, payload, tkeep, tid, tdest, and go to READ_SEQ; BRAM EN=1, WEN=0, ADDR=sender<<2 in that same cycle.
REQ-014 BRAM read latency SHALL be 1 cycle; READ_SEQ->CHECK unconditionally; DOUT sampled in CHECK.
REQ-015 CHECK: seq == DOUT+1 (mod 2^LAN_SEQUENCE_NUMBER_WIDTH) -> DELIVER; seq == DOUT -> SEND_ACK (duplicate, no delivery, no write); otherwise -> IDLE, no ACK, no write.
REQ-016 DELIVER: to_node_tvalid=1 with payload zero-extended in tdata[PUB_DATA_WIDTH-1:0], latched tkeep/tid/tdest, tlast=1; data stable until to_node_tready.
REQ-017 On the DELIVER handshake, BRAM SHALL write: EN=1, WEN=4'hF, ADDR=sender<<2, DIN=seq; state -> SEND_ACK.
REQ-018 SEND_ACK: to_nb_ack_tvalid=1, tdata type=ACK, sender field=i_node_id, sequence field=latched seq, other bits 0; tdest=latched sender; tuser=1; tlast=1; -> IDLE on to_nb_ack_tready.
REQ-019 Wrap-around: stored all-ones, incoming 0 SHALL be treated as new.
REQ-020 BRAM EN/WEN SHALL be 0 in all cycles not named in REQ-013/REQ-017.
REQ-021 to_node_tvalid and to_nb_ack_tvalid SHALL never be 1 in the same cycle.

Reset
REQ-022 Reset SHALL force INIT and clear all latched registers to 0; all tvalid, tready, BRAM EN and WEN SHALL read 0 while reset is asserted.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction with no BRAM write and no ACK.

Verification
REQ-024 init held 0 and PUB presented -> tready stays 0; then init=1 -> tready=1 one cycle later.
REQ-025 PUB sender=3, seq=5, BRAM[12]=4 -> one to_node beat carrying the payload; BRAM write addr 12, data 5; ACK with tdest=3, seq=5.
REQ-026 Same PUB resent with BRAM[12]=5 -> no to_node beat, no BRAM write, ACK seq=5.
REQ-027 PUB seq=9 with BRAM=4 -> dropped, no ACK, back in IDLE 3 cycles after acceptance.
REQ-028 BRAM=16'hFFFF, seq=0 -> delivered, BRAM written with 0, ACK seq=0; to_node_tready held 0 for 10 cycles -> tvalid held and data stable throughout.
REQ-029 ACK-type beat in IDLE -> consumed, no outputs, no BRAM access; reset asserted during DELIVER -> INIT, no write, no ACK.
